mc_seq_ctrl: RTL and testbench

Parametrised multicycle sequencer for the RV32I core. It owns the PC, the instruction register and the FSM that drives the datapath control strobes. It uses a single shared memory port with a req/ack handshake, so instruction and data memory may insert wait states. Illegal opcodes, misaligned jump targets and memory timeouts trap the core instead of hanging it.

---
 rtl/mc_seq_ctrl_if.sv | 27 ++
 rtl/mc_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mc_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_ctrl_if.sv
// Shared memory port of the multicycle sequencer: one request/ack channel
// used for instruction fetch as well as loads and stores.
interface mc_seq_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multicycle RV32I sequencer: owns PC, IR and instret, and drives the
// datapath strobes. Fetch and data accesses share one req/ack memory port;
// illegal opcodes, misaligned jump targets and memory timeouts trap.
module mc_seq_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 8,
    parameter int              PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    mc_seq_ctrl_if.master       bus,
    input  logic [XLEN-1:0]     i_imm,
    input  logic [XLEN-1:0]     i_alu_res,
    input  logic                i_branch_taken,
    output logic [XLEN-1:0]     o_pc,
    output logic [31:0]         o_ir,
    output logic                o_alu_src_imm,
    output logic                o_alu_a_pc,
    output logic                o_reg_we,
    output logic [1:0]          o_wb_sel,
    output logic [3:0]          o_state,
    output logic [1:0]          o_trap_cause,
    output logic [31:0]         o_instret
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_OPIMM  = 4'd3,
        S_OP     = 4'd4,
        S_JAL    = 4'd5,
        S_JALR   = 4'd6,
        S_LUI    = 4'd7,
        S_AUIPC  = 4'd8,
        S_LOAD   = 4'd9,
        S_STORE  = 4'd10,
        S_BRANCH = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              ALIGN_CHK = (PC_STEP == 4);

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_instret;
    logic [1:0]        r_trap_cause;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic [XLEN-1:0]   w_next_pc;
    logic [1:0]        w_next_cause;
    logic              w_load_ir;
    logic              w_retire;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_alu_src_imm;
    logic              w_alu_a_pc;
    logic              w_reg_we;
    logic [1:0]        w_wb_sel;
    logic              w_timeout;

    // Candidate PC values; jump targets are checked for word alignment when byte-addressed.
    logic [XLEN-1:0]   w_pc_step;
    logic [XLEN-1:0]   w_pc_imm;
    logic [XLEN-1:0]   w_jalr_target;
    logic              w_pc_imm_misal;
    logic              w_jalr_misal;

    assign w_pc_step      = r_pc + XLEN'(PC_STEP);
    assign w_pc_imm       = r_pc + i_imm;
    assign w_jalr_target  = i_alu_res & ~XLEN'(1);
    assign w_pc_imm_misal = ALIGN_CHK && (w_pc_imm[1:0] != 2'b00);
    assign w_jalr_misal   = ALIGN_CHK && (w_jalr_target[1:0] != 2'b00);
    assign w_timeout      = (TIMEOUT != 0) && (r_wait_cnt == TO_LAST);

    // FSM state register; reset abandons any outstanding memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC, IR, trap cause, retirement count and memory wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_instret    <= '0;
            r_trap_cause <= 2'd0;
            r_wait_cnt   <= '0;
        end else begin
            r_pc         <= w_next_pc;
            r_trap_cause <= w_next_cause;
            if (w_load_ir) begin
                r_ir <= bus.mem_rdata;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if (TIMEOUT != 0 && w_mem_req && !bus.mem_ack) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state, next-PC and datapath strobes for the current state.
    always_comb begin
        w_next_state  = r_state;
        w_next_pc     = r_pc;
        w_next_cause  = r_trap_cause;
        w_load_ir     = 1'b0;
        w_retire      = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = '0;
        w_alu_src_imm = 1'b0;
        w_alu_a_pc    = 1'b0;
        w_reg_we      = 1'b0;
        w_wb_sel      = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_pc[ADDR_W-1:0];
                if (bus.mem_ack) begin
                    w_load_ir    = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd2;
                end
            end
            S_DECODE: begin
                case (r_ir[6:0])
                    7'b0010011: w_next_state = S_OPIMM;
                    7'b0110011: w_next_state = S_OP;
                    7'b0110111: w_next_state = S_LUI;
                    7'b0010111: w_next_state = S_AUIPC;
                    7'b1101111: w_next_state = S_JAL;
                    7'b1100111: w_next_state = S_JALR;
                    7'b0000011: w_next_state = S_LOAD;
                    7'b0100011: w_next_state = S_STORE;
                    7'b1100011: w_next_state = S_BRANCH;
                    default: begin
                        w_next_state = S_TRAP;
                        w_next_cause = 2'd1;
                    end
                endcase
            end
            S_OPIMM: begin
                w_alu_src_imm = 1'b1;
                w_reg_we      = 1'b1;
                w_next_pc     = w_pc_step;
                w_retire      = 1'b1;
                w_next_state  = S_FETCH;
            end
            S_OP: begin
                w_reg_we     = 1'b1;
                w_next_pc    = w_pc_step;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_LUI: begin
                w_reg_we     = 1'b1;
                w_wb_sel     = 2'd2;
                w_next_pc    = w_pc_step;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_AUIPC: begin
                w_alu_a_pc    = 1'b1;
                w_alu_src_imm = 1'b1;
                w_reg_we      = 1'b1;
                w_next_pc     = w_pc_step;
                w_retire      = 1'b1;
                w_next_state  = S_FETCH;
            end
            S_JAL: begin
                if (w_pc_imm_misal) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd3;
                end else begin
                    w_reg_we     = 1'b1;
                    w_wb_sel     = 2'd3;
                    w_next_pc    = w_pc_imm;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_JALR: begin
                w_alu_src_imm = 1'b1;
                if (w_jalr_misal) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd3;
                end else begin
                    w_reg_we     = 1'b1;
                    w_wb_sel     = 2'd3;
                    w_next_pc    = w_jalr_target;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                if (i_branch_taken && w_pc_imm_misal) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd3;
                end else begin
                    w_next_pc    = i_branch_taken ? w_pc_imm : w_pc_step;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_LOAD, S_STORE: begin
                w_alu_src_imm = 1'b1;
                w_mem_req     = 1'b1;
                w_mem_we      = (r_state == S_STORE);
                w_mem_addr    = i_alu_res[ADDR_W-1:0];
                if (bus.mem_ack) begin
                    if (r_state == S_LOAD) begin
                        w_reg_we = 1'b1;
                        w_wb_sel = 2'd1;
                    end
                    w_next_pc    = w_pc_step;
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                    w_next_cause = 2'd2;
                end
            end
            S_TRAP: begin
                if (i_start) begin
                    w_next_cause = 2'd0;
                    w_next_pc    = RESET_PC;
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign o_pc           = r_pc;
    assign o_ir           = r_ir;
    assign o_alu_src_imm  = w_alu_src_imm;
    assign o_alu_a_pc     = w_alu_a_pc;
    assign o_reg_we       = w_reg_we;
    assign o_wb_sel       = w_wb_sel;
    assign o_state        = r_state;
    assign o_trap_cause   = r_trap_cause;
    assign o_instret      = r_instret;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Testbench for mc_seq_ctrl: directed scenarios followed by random
// instruction streams, checked against an instruction-level reference model.
module tb_mc_seq_ctrl;

    localparam int          TIMEOUT  = 15;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] imm;
    logic [31:0] alu_res;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        alu_src_imm;
    logic        alu_a_pc;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [3:0]  state;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] mPc;
    logic [31:0] mInstret;
    logic [1:0]  mCause;

    mc_seq_ctrl_if #(.ADDR_W(8)) bus ();

    mc_seq_ctrl #(
        .XLEN     (32),
        .ADDR_W   (8),
        .PC_STEP  (4),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .bus            (bus),
        .i_imm          (imm),
        .i_alu_res      (alu_res),
        .i_branch_taken (taken),
        .o_pc           (pc),
        .o_ir           (ir),
        .o_alu_src_imm  (alu_src_imm),
        .o_alu_a_pc     (alu_a_pc),
        .o_reg_we       (reg_we),
        .o_wb_sel       (wb_sel),
        .o_state        (state),
        .o_trap_cause   (trap_cause),
        .o_instret      (instret)
    );

    always #5 clk = ~clk;

    // What one instruction should do, derived from its architectural meaning.
    typedef struct {
        logic       legal;
        logic [3:0] st;
        logic       isMem;
        logic       isStore;
        logic       we;
        logic [1:0] wb;
        logic       srcImm;
        logic       aPc;
        logic [1:0] cause;
        logic [31:0] nextPc;
    } exp_t;

    function automatic exp_t predict(input logic [31:0] instr, input logic [31:0] curPc,
                                     input logic [31:0] immV, input logic [31:0] aluV,
                                     input logic tk);
        exp_t e;
        logic [31:0] target;
        e.legal = 1'b1; e.st = 4'd0; e.isMem = 1'b0; e.isStore = 1'b0; e.we = 1'b0;
        e.wb = 2'd0; e.srcImm = 1'b0; e.aPc = 1'b0; e.cause = 2'd0;
        e.nextPc = curPc + 32'd4;
        case (instr[6:0])
            7'h13: begin e.st = 4'd3; e.we = 1'b1; e.srcImm = 1'b1; end
            7'h33: begin e.st = 4'd4; e.we = 1'b1; end
            7'h37: begin e.st = 4'd7; e.we = 1'b1; e.wb = 2'd2; end
            7'h17: begin e.st = 4'd8; e.we = 1'b1; e.srcImm = 1'b1; e.aPc = 1'b1; end
            7'h6F: begin
                e.st = 4'd5;
                target = curPc + immV;
                if (target % 4 != 0) e.cause = 2'd3;
                else begin e.we = 1'b1; e.wb = 2'd3; e.nextPc = target; end
            end
            7'h67: begin
                e.st = 4'd6; e.srcImm = 1'b1;
                target = aluV - (aluV % 2);
                if (target % 4 != 0) e.cause = 2'd3;
                else begin e.we = 1'b1; e.wb = 2'd3; e.nextPc = target; end
            end
            7'h63: begin
                e.st = 4'd11;
                if (tk) begin
                    target = curPc + immV;
                    if (target % 4 != 0) e.cause = 2'd3;
                    else e.nextPc = target;
                end
            end
            7'h03: begin e.st = 4'd9;  e.isMem = 1'b1; e.srcImm = 1'b1; e.we = 1'b1; e.wb = 2'd1; end
            7'h23: begin e.st = 4'd10; e.isMem = 1'b1; e.isStore = 1'b1; e.srcImm = 1'b1; end
            default: begin e.legal = 1'b0; e.cause = 2'd1; end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nTests++;
        assert (obs === expv) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] immV, input logic [31:0] aluV, input logic tk);
        imm     = immV;
        alu_res = aluV;
        taken   = tk;
    endtask

    // Pulse start from TRAP/IDLE; the model restarts at RESET_PC.
    task automatic restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("restart_state", state, 4'd1);
        checkOutput("restart_pc", pc, RESET_PC);
        checkOutput("restart_cause", trap_cause, 2'd0);
        mPc    = RESET_PC;
        mCause = 2'd0;
    endtask

    // Fetch, decode and execute one instruction, checking every cycle.
    task automatic runInstr(input logic [31:0] instr, input int fWait, input logic [31:0] immV,
                            input logic [31:0] aluV, input logic tk, input int mWait);
        exp_t e;
        e = predict(instr, mPc, immV, aluV, tk);
        applyStimulus(immV, aluV, tk);
        for (int k = 0; k <= fWait; k++) begin
            bus.mem_ack   = (k == fWait);
            bus.mem_rdata = (k == fWait) ? instr : $urandom();
            #1;
            checkOutput("fetch_state", state, 4'd1);
            checkOutput("fetch_req", bus.mem_req, 1'b1);
            checkOutput("fetch_we", bus.mem_we, 1'b0);
            checkOutput("fetch_addr", bus.mem_addr, mPc[7:0]);
            checkOutput("fetch_regwe", reg_we, 1'b0);
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        #1;
        checkOutput("decode_state", state, 4'd2);
        checkOutput("decode_ir", ir, instr);
        checkOutput("decode_req", bus.mem_req, 1'b0);
        @(negedge clk);
        if (e.legal) begin
            #1;
            checkOutput("exec_state", state, e.st);
            checkOutput("exec_srcimm", alu_src_imm, e.srcImm);
            if (e.isMem) begin
                for (int k = 0; k <= mWait; k++) begin
                    bus.mem_ack = (k == mWait);
                    #1;
                    checkOutput("mem_req", bus.mem_req, 1'b1);
                    checkOutput("mem_we", bus.mem_we, e.isStore);
                    checkOutput("mem_addr", bus.mem_addr, aluV[7:0]);
                    checkOutput("mem_regwe", reg_we, (k == mWait) && e.we);
                    if (k == mWait && e.we) checkOutput("mem_wbsel", wb_sel, e.wb);
                    @(negedge clk);
                end
                bus.mem_ack = 1'b0;
            end else begin
                checkOutput("exec_req", bus.mem_req, 1'b0);
                checkOutput("exec_regwe", reg_we, e.we);
                checkOutput("exec_apc", alu_a_pc, e.aPc);
                if (e.we) checkOutput("exec_wbsel", wb_sel, e.wb);
                @(negedge clk);
            end
        end
        #1;
        if (e.cause != 2'd0) begin
            mCause = e.cause;
            checkOutput("trap_state", state, 4'd15);
            checkOutput("trap_cause", trap_cause, e.cause);
            checkOutput("trap_pc", pc, mPc);
            checkOutput("trap_instret", instret, mInstret);
            checkOutput("trap_req", bus.mem_req, 1'b0);
            checkOutput("trap_regwe", reg_we, 1'b0);
        end else begin
            mPc      = e.nextPc;
            mInstret = mInstret + 32'd1;
            checkOutput("retire_state", state, 4'd1);
            checkOutput("retire_pc", pc, mPc);
            checkOutput("retire_instret", instret, mInstret);
        end
    endtask

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, tests=%0d failed=%0d", nTests, nFail);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized instruction streams.
    initial begin
        logic [6:0]  opTab [10];
        logic [31:0] r;
        logic [31:0] rImm;
        int          cnt;

        opTab = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F};
        rst = 1'b0; start = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        applyStimulus(32'h0, 32'h0, 1'b0);
        mPc = RESET_PC; mInstret = 32'h0; mCause = 2'd0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_state", state, 4'd0);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_instret", instret, 32'h0);
        checkOutput("rst_cause", trap_cause, 2'd0);
        checkOutput("rst_req", bus.mem_req, 1'b0);
        checkOutput("rst_addr", bus.mem_addr, 8'h0);
        checkOutput("rst_wbsel", wb_sel, 2'd0);
        checkOutput("rst_regwe", reg_we, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // A stray ack while idle must not move the FSM.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        checkOutput("idle_ack_ignored", state, 4'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("start_state", state, 4'd1);

        runInstr(32'h00500093, 0, 32'd5, 32'd5, 1'b0, 0);
        checkOutput("addi_pc", pc, 32'h4);
        checkOutput("addi_instret", instret, 32'd1);
        runInstr(32'h002081B3, 1, 32'h0, 32'h0, 1'b0, 0);
        runInstr(32'h123450B7, 2, 32'h12345000, 32'h0, 1'b0, 0);
        runInstr(32'h00001097, 0, 32'h1000, 32'h0, 1'b0, 0);
        runInstr(32'h008000EF, 0, 32'h8, 32'h0, 1'b0, 0);
        checkOutput("jal_pc", pc, 32'h18);
        runInstr(32'h000080E7, 0, 32'h0, 32'h31, 1'b0, 0);
        checkOutput("jalr_pc", pc, 32'h30);
        runInstr(32'h00112023, 0, 32'h0, 32'h44, 1'b0, 2);
        runInstr(32'h0200A083, 0, 32'h20, 32'h20, 1'b0, 3);
        runInstr(32'h002081B3, 0, 32'h0, 32'h0, 1'b0, 0);
        runInstr(32'h002081B3, 0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("pre_beq_pc", pc, 32'h40);
        runInstr(32'h00000063, 0, 32'hFFFFFFF8, 32'h0, 1'b1, 0);
        checkOutput("beq_taken_pc", pc, 32'h38);
        runInstr(32'h002081B3, 0, 32'h0, 32'h0, 1'b0, 0);
        runInstr(32'h002081B3, 0, 32'h0, 32'h0, 1'b0, 0);
        runInstr(32'h00000063, 0, 32'hFFFFFFF8, 32'h0, 1'b0, 0);
        checkOutput("beq_nottaken_pc", pc, 32'h44);
        runInstr(32'h008000EF, 0, 32'hFFFFFFFC, 32'h0, 1'b0, 0);
        runInstr(32'h00000063, 0, 32'h6, 32'h0, 1'b1, 0);
        checkOutput("beq_misal_cause", trap_cause, 2'd3);
        checkOutput("beq_misal_pc", pc, 32'h40);
        restart();

        runInstr(32'h0000007F, 0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("illegal_cause", trap_cause, 2'd1);
        restart();

        // Fetch with no ack: count request cycles until the trap.
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (state == 4'd15) break;
            if (bus.mem_req) cnt++;
            @(negedge clk);
            #1;
        end
        checkOutput("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
        checkOutput("timeout_state", state, 4'd15);
        checkOutput("timeout_cause", trap_cause, 2'd2);
        checkOutput("timeout_req", bus.mem_req, 1'b0);
        checkOutput("timeout_instret", instret, mInstret);
        restart();

        // Asynchronous reset in the middle of a load wait.
        bus.mem_rdata = 32'h0200A083;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        applyStimulus(32'h20, 32'h20, 1'b0);
        #1;
        checkOutput("load_wait_state", state, 4'd9);
        checkOutput("load_wait_req", bus.mem_req, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_state", state, 4'd0);
        checkOutput("async_rst_pc", pc, RESET_PC);
        checkOutput("async_rst_ir", ir, 32'h0);
        checkOutput("async_rst_instret", instret, 32'h0);
        checkOutput("async_rst_req", bus.mem_req, 1'b0);
        checkOutput("async_rst_addr", bus.mem_addr, 8'h0);
        checkOutput("async_rst_srcimm", alu_src_imm, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mPc = RESET_PC; mInstret = 32'h0; mCause = 2'd0;
        restart();

        // Random instruction stream; traps are restarted as they occur.
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            if ($urandom_range(0, 3) == 0) rImm = $urandom();
            else rImm = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
            runInstr({r[31:7], opTab[$urandom_range(0, 9)]}, $urandom_range(0, 3), rImm,
                     $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if (mCause != 2'd0) restart();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
